fifo_bank4: RTL and testbench
=============================

# fifo_bank4

Four independent 12-bit FIFOs that buffer the per-class streams leaving the class demultiplexer. Each push_N/data_inN pair from the demux writes into its own FIFO. Downstream consumers drain each FIFO with pop_N. The bank provides per-FIFO occupancy flags for flow control and sticky error flags for overflow and underflow.

## Interface
- DATA_W, 12, word width (matches the demux data path)
- DEPTH, 8, entries per FIFO; power of two, ≥4
- AF_THRESH, 6, almost_full_N asserted when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty_N asserted when count ≤ AE_THRESH

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- push_0..push_3  in  1 each  write strobe per class
- data_in0..data_in3  in  DATA_W each  write data per class
- pop_0..pop_3  in  1 each  read strobe per class
- data_out0..data_out3  out  DATA_W each  registered read data
- valid_0..valid_3  out  1 each  data_outN holds a freshly popped word this cycle
- empty_0..3, full_0..3, almost_empty_0..3, almost_full_0..3  out  1 each  occupancy flags
- err_0..err_3  out  1 each  sticky error flag: overflow or underflow since reset

## Operation
- Each FIFO has:
  - write pointer, read pointer: log2(DEPTH) bits, wrap modulo DEPTH
  - count: log2(DEPTH)+1 bits, range 0..DEPTH
- The four FIFOs are fully independent. No arbitration between classes.
- Push accepted when push_N && (!full_N || pop_N):
  - mem[wr] ← data_inN
  - wr++
- Pop accepted when pop_N && !empty_N:
  - data_outN ← mem[rd]
  - rd++
  - valid_N = 1 next cycle
- count update: +1 on push only; −1 on pop only; unchanged on both or neither.
- Push when full with no pop (overflow):
  - data dropped; memory, pointers and count unchanged
  - err_N set
- Pop when empty (underflow):
  - ignored; data_outN holds its last value; valid_N = 0
  - err_N set
- Push and pop when empty: push accepted, pop is an underflow (err_N set), count becomes 1. No fall-through path.
- Push and pop when full: both accepted; count stays DEPTH.
- Flags are combinational from the registered count:
  - empty = (count == 0)
  - full = (count == DEPTH)
  - almost_empty = (count ≤ AE_THRESH)
  - almost_full = (count ≥ AF_THRESH)
- err_N clears only on reset.
- Reset values (applied on any clock edge with reset = 1, including mid-stream):
  - pointers and count = 0
  - data_outN = 0, valid_N = 0, err_N = 0
  - empty_N = 1, almost_empty_N = 1, full_N = 0, almost_full_N = 0
  - memory contents not cleared
  - push/pop in the reset cycle are ignored

## Timing
- Write latency: a word pushed at edge k is poppable at edge k+1. empty_N falls after edge k.
- Read latency: 1 cycle. pop_N sampled at edge k → data_outN/valid_N valid after edge k, held until the next accepted pop. valid_N is a single-cycle pulse per accepted pop.
- Back-to-back pops at full rate yield one word per cycle in FIFO order.
- Flags reflect the count after the most recent edge. The demux must sample full_N before asserting push_N; the bank tolerates violations by dropping the word and setting err_N.
- Throughput: one push and one pop per FIFO per cycle.

## Structure
- Shared package/header: DATA_W default, DEPTH default, threshold defaults, and the pointer-width derivation (log2 DEPTH).
- Natural sub-module: fifo_sync, a single FIFO with push, data_in, pop, data_out, valid, the four flags and err. fifo_bank4 instantiates it four times and does no other logic.
- Verify fifo_sync standalone before the bank.

## Test plan
- Reset then idle:
  - all empty_N = 1, full_N = 0, almost_empty_N = 1, err_N = 0, valid_N = 0, data_outN = 0.
- Push 1, 2, 3, 4 into classes 0, 1, 2, 3 on consecutive cycles, then pop all four together:
  - data_out0..3 = 1, 2, 3, 4 with valid_0..3 = 1 in the same cycle.
  - all FIFOs empty afterwards.
- Fill class 0 with 0x001..0x008:
  - almost_full_0 rises at count 6; full_0 at count 8.
  - then push 0x0FF: dropped, err_0 = 1.
  - eight pops return 0x001..0x008 in order; empty_0 = 1.
- Class 1 at count 8, simultaneous push 0xABC and pop:
  - data_out1 = oldest word; count stays 8; err_1 = 0.
  - drain → 0xABC is last out.
- Class 2 empty, pop_2 alone:
  - valid_2 = 0, data_out2 unchanged, err_2 = 1.
  - then push 0x123 with pop: count = 1; next pop returns 0x123.
- Class 3 at count 5, assert reset for one cycle with push_3 = 1:
  - count 0, empty_3 = 1, err_3 = 0, no word written.
  - the following push/pop of 0x777 returns 0x777.

Source files
------------

// File: rtl/fifo_bank4_pkg.sv
// Shared sizing for the per-class FIFO bank.
// Widths and thresholds used by fifo_sync and fifo_bank4.
package fifo_bank4_pkg;

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AF_THRESH = 6;
    localparam int unsigned AE_THRESH = 2;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

endpackage

// File: rtl/fifo_sync.sv
// Single synchronous FIFO with registered read data, occupancy flags
// and a sticky overflow/underflow error flag.
module fifo_sync
    import fifo_bank4_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic              err_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q;
    logic              err_q, err_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty_o        = (cnt_q == '0);
    assign full_o         = (cnt_q == CNT_W'(DEPTH));
    assign almost_empty_o = (cnt_q <= CNT_W'(AE_THRESH));
    assign almost_full_o  = (cnt_q >= CNT_W'(AF_THRESH));

    // A pop frees the slot a full-FIFO push lands in during the same edge.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        err_d  = err_q;
        if (push_ok) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_d   = rd_q + PTR_W'(1);
            data_d = mem_q[rd_q];
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if ((pop_i && empty_o) || (push_i && full_o && !pop_i)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= pop_ok;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/fifo_bank4.sv
// Four independent per-class FIFOs fed by the class demultiplexer.
// Pure structural wrapper around four fifo_sync instances.
module fifo_bank4
    import fifo_bank4_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_0,
    input  logic              push_1,
    input  logic              push_2,
    input  logic              push_3,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              pop_0,
    input  logic              pop_1,
    input  logic              pop_2,
    input  logic              pop_3,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              valid_0,
    output logic              valid_1,
    output logic              valid_2,
    output logic              valid_3,
    output logic              empty_0,
    output logic              empty_1,
    output logic              empty_2,
    output logic              empty_3,
    output logic              full_0,
    output logic              full_1,
    output logic              full_2,
    output logic              full_3,
    output logic              almost_empty_0,
    output logic              almost_empty_1,
    output logic              almost_empty_2,
    output logic              almost_empty_3,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              almost_full_2,
    output logic              almost_full_3,
    output logic              err_0,
    output logic              err_1,
    output logic              err_2,
    output logic              err_3
);

    fifo_sync u_fifo0 (
        .clk_i          (clk),
        .reset_i        (reset),
        .push_i         (push_0),
        .data_i         (data_in0),
        .pop_i          (pop_0),
        .data_o         (data_out0),
        .valid_o        (valid_0),
        .empty_o        (empty_0),
        .full_o         (full_0),
        .almost_empty_o (almost_empty_0),
        .almost_full_o  (almost_full_0),
        .err_o          (err_0)
    );

    fifo_sync u_fifo1 (
        .clk_i          (clk),
        .reset_i        (reset),
        .push_i         (push_1),
        .data_i         (data_in1),
        .pop_i          (pop_1),
        .data_o         (data_out1),
        .valid_o        (valid_1),
        .empty_o        (empty_1),
        .full_o         (full_1),
        .almost_empty_o (almost_empty_1),
        .almost_full_o  (almost_full_1),
        .err_o          (err_1)
    );

    fifo_sync u_fifo2 (
        .clk_i          (clk),
        .reset_i        (reset),
        .push_i         (push_2),
        .data_i         (data_in2),
        .pop_i          (pop_2),
        .data_o         (data_out2),
        .valid_o        (valid_2),
        .empty_o        (empty_2),
        .full_o         (full_2),
        .almost_empty_o (almost_empty_2),
        .almost_full_o  (almost_full_2),
        .err_o          (err_2)
    );

    fifo_sync u_fifo3 (
        .clk_i          (clk),
        .reset_i        (reset),
        .push_i         (push_3),
        .data_i         (data_in3),
        .pop_i          (pop_3),
        .data_o         (data_out3),
        .valid_o        (valid_3),
        .empty_o        (empty_3),
        .full_o         (full_3),
        .almost_empty_o (almost_empty_3),
        .almost_full_o  (almost_full_3),
        .err_o          (err_3)
    );

endmodule

// File: tb/tb_fifo_bank4.sv
// Scenario bench for fifo_bank4 with a per-class queue model and
// scoreboard of expected read data.
module tb_fifo_bank4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push [4];
    logic        pop  [4];
    logic [11:0] din  [4];
    logic [11:0] dout [4];
    logic        valid[4];
    logic        empty[4];
    logic        full [4];
    logic        aemp [4];
    logic        afull[4];
    logic        err  [4];

    logic [11:0] mq   [4][$];
    logic [11:0] expq [4][$];
    logic [11:0] mdout[4];
    logic        merr [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_bank4 dut (
        .clk(clk), .reset(reset),
        .push_0(push[0]), .push_1(push[1]), .push_2(push[2]), .push_3(push[3]),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .pop_0(pop[0]), .pop_1(pop[1]), .pop_2(pop[2]), .pop_3(pop[3]),
        .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
        .valid_0(valid[0]), .valid_1(valid[1]), .valid_2(valid[2]), .valid_3(valid[3]),
        .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]), .empty_3(empty[3]),
        .full_0(full[0]), .full_1(full[1]), .full_2(full[2]), .full_3(full[3]),
        .almost_empty_0(aemp[0]), .almost_empty_1(aemp[1]),
        .almost_empty_2(aemp[2]), .almost_empty_3(aemp[3]),
        .almost_full_0(afull[0]), .almost_full_1(afull[1]),
        .almost_full_2(afull[2]), .almost_full_3(afull[3]),
        .err_0(err[0]), .err_1(err[1]), .err_2(err[2]), .err_3(err[3])
    );

    function automatic logic [47:0] at(input int c, input logic [11:0] d);
        return 48'(d) << (c * 12);
    endfunction

    // Drive one cycle, advance the model, then score the DUT outputs.
    task automatic step(input logic rst, input logic [3:0] pu,
                        input logic [3:0] po, input logic [47:0] dv);
        reset = rst;
        for (int c = 0; c < 4; c++) begin
            push[c] = pu[c];
            pop[c]  = po[c];
            din[c]  = dv[c*12 +: 12];
            if (rst) begin
                mq[c].delete();
                expq[c].delete();
                mdout[c] = '0;
                merr[c]  = 1'b0;
            end else begin
                if ((po[c] && mq[c].size() == 0) ||
                    (pu[c] && mq[c].size() == 8 && !po[c]))
                    merr[c] = 1'b1;
                if (pu[c] && po[c] && mq[c].size() == 0) begin
                    mq[c].push_back(dv[c*12 +: 12]);
                end else begin
                    if (po[c] && mq[c].size() != 0)
                        expq[c].push_back(mq[c].pop_front());
                    if (pu[c] && (mq[c].size() < 8 || po[c]))
                        mq[c].push_back(dv[c*12 +: 12]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            logic ev;
            ev = (expq[c].size() != 0);
            checks++;
            if (valid[c] !== ev) begin
                errors++;
                $display("FAIL valid%0d: got %b want %b", c, valid[c], ev);
            end
            if (ev) mdout[c] = expq[c].pop_front();
            checks++;
            if (dout[c] !== mdout[c]) begin
                errors++;
                $display("FAIL data_out%0d: got %h want %h", c, dout[c], mdout[c]);
            end
            checks++;
            if (err[c] !== merr[c]) begin
                errors++;
                $display("FAIL err%0d: got %b want %b", c, err[c], merr[c]);
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 4'h0, 4'h0, '0);
        step(1'b0, 4'h0, 4'h0, '0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({empty[c], full[c], aemp[c], afull[c], err[c], valid[c]} !== 6'b101000) begin
                errors++;
                $display("FAIL reset_flags%0d: got %b want 101000", c,
                         {empty[c], full[c], aemp[c], afull[c], err[c], valid[c]});
            end
            checks++;
            if (dout[c] !== 12'h000) begin
                errors++;
                $display("FAIL reset_dout%0d: got %h want 000", c, dout[c]);
            end
        end
    endtask

    task automatic test_four_classes();
        for (int c = 0; c < 4; c++)
            step(1'b0, 4'(1 << c), 4'h0, at(c, 12'(c + 1)));
        step(1'b0, 4'h0, 4'hF, '0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (valid[c] !== 1'b1 || dout[c] !== 12'(c + 1)) begin
                errors++;
                $display("FAIL parallel_pop%0d: got %b/%h want 1/%h",
                         c, valid[c], dout[c], 12'(c + 1));
            end
        end
        step(1'b0, 4'h0, 4'h0, '0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (empty[c] !== 1'b1) begin
                errors++;
                $display("FAIL drained_empty%0d: got %b want 1", c, empty[c]);
            end
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 4'h1, 4'h0, at(0, 12'(i)));
            checks++;
            if ({afull[0], full[0], aemp[0]} !== {i >= 6, i == 8, i <= 2}) begin
                errors++;
                $display("FAIL fill_flags count=%0d: got %b want %b", i,
                         {afull[0], full[0], aemp[0]}, {i >= 6, i == 8, i <= 2});
            end
        end
        step(1'b0, 4'h1, 4'h0, at(0, 12'h0FF));
        checks++;
        if (err[0] !== 1'b1 || full[0] !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got err=%b full=%b want 1 1", err[0], full[0]);
        end
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'h0, 4'h1, '0);
        checks++;
        if (empty[0] !== 1'b1 || dout[0] !== 12'h008) begin
            errors++;
            $display("FAIL overflow_drain: got empty=%b dout=%h want 1 008",
                     empty[0], dout[0]);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'h2, 4'h0, at(1, 12'(12'h100 + i)));
        step(1'b0, 4'h2, 4'h2, at(1, 12'hABC));
        checks++;
        if (full[1] !== 1'b1 || err[1] !== 1'b0 || dout[1] !== 12'h100) begin
            errors++;
            $display("FAIL full_pushpop: got full=%b err=%b dout=%h want 1 0 100",
                     full[1], err[1], dout[1]);
        end
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'h0, 4'h2, '0);
        checks++;
        if (dout[1] !== 12'hABC || empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_last: got dout=%h empty=%b want ABC 1",
                     dout[1], empty[1]);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 4'h0, 4'h4, '0);
        checks++;
        if (valid[2] !== 1'b0 || dout[2] !== 12'h003 || err[2] !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got v=%b dout=%h err=%b want 0 003 1",
                     valid[2], dout[2], err[2]);
        end
        step(1'b0, 4'h4, 4'h4, at(2, 12'h123));
        checks++;
        if (empty[2] !== 1'b0 || aemp[2] !== 1'b1 || valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL empty_pushpop: got empty=%b ae=%b v=%b want 0 1 0",
                     empty[2], aemp[2], valid[2]);
        end
        step(1'b0, 4'h0, 4'h4, '0);
        checks++;
        if (dout[2] !== 12'h123 || empty[2] !== 1'b1) begin
            errors++;
            $display("FAIL underflow_next: got dout=%h empty=%b want 123 1",
                     dout[2], empty[2]);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++)
            step(1'b0, 4'h8, 4'h0, at(3, 12'(12'h300 + i)));
        step(1'b1, 4'h8, 4'h0, at(3, 12'h555));
        checks++;
        if (empty[3] !== 1'b1 || err[3] !== 1'b0 || dout[3] !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset: got empty=%b err=%b dout=%h want 1 0 000",
                     empty[3], err[3], dout[3]);
        end
        step(1'b0, 4'h8, 4'h0, at(3, 12'h777));
        step(1'b0, 4'h0, 4'h8, '0);
        checks++;
        if (dout[3] !== 12'h777 || valid[3] !== 1'b1 || empty[3] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: got dout=%h v=%b empty=%b want 777 1 1",
                     dout[3], valid[3], empty[3]);
        end
        step(1'b0, 4'h0, 4'h0, '0);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            push[c]  = 1'b0;
            pop[c]   = 1'b0;
            din[c]   = '0;
            mdout[c] = '0;
            merr[c]  = 1'b0;
        end
        test_reset();
        test_four_classes();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
